// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the rotate-priority helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int DW_DEFAULT = 8;
  localparam int MAXREQ     = 8;

  // First set bit of req at or after ptr, wrapping modulo n; result is one-hot or zero.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int                n);
    logic [MAXREQ-1:0] sel;
    logic              found;
    logic [3:0]        j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      if (k < n) begin
        j = {1'b0, ptr} + 4'(k);
        if (j >= 4'(n)) j = j - 4'(n);
        if (!found && req[j[2:0]]) begin
          sel[j[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    last;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      fifo_din;
  logic               fifo_wr;
  logic               fifo_full;
  logic               busy;

  modport master (
    output req, data, last, fifo_full,
    input  ack, gnt, fifo_din, fifo_wr, busy
  );

  modport slave (
    input  req, data, last, fifo_full,
    output ack, gnt, fifo_din, fifo_wr, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: one-hot pick and index of the first request from rr_ptr.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx
);
  logic [MAXREQ-1:0] req8;
  logic [MAXREQ-1:0] pick8;

  always_comb begin
    req8            = '0;
    req8[NREQ-1:0]  = req;
    pick8           = rr_pick(req8, 3'(rr_ptr), NREQ);
    pick            = pick8[NREQ-1:0];
    idx             = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (pick8[i]) idx = PW'(i);
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers, in bursts of up to MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = 4
)(
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

  state_t          state;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   pick_idx;
  logic [CW-1:0]   burst_cnt;
  logic            req_g;
  logic            last_g;
  logic            wr;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx)
  );

  // gnt is zero or one-hot, so masking and OR-reducing selects the granted producer.
  always_comb begin
    req_g        = |(gnt & bus.req);
    last_g       = |(gnt & bus.last);
    wr           = req_g & ~bus.fifo_full;
    bus.fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) bus.fifo_din = bus.data[i*DW +: DW];
    end
  end

  assign bus.gnt     = gnt;
  assign bus.fifo_wr = wr;
  assign bus.ack     = wr ? gnt : '0;
  assign bus.busy    = (state == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt       <= pick;
            gidx      <= pick_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (wr) burst_cnt <= burst_cnt + 1'b1;
          // Withdrawal, final word, or full burst all release on this edge; the IDLE cycle that follows is the bubble.
          if (!req_g || (wr && (last_g || burst_cnt == BURST_END))) begin
            gnt    <= '0;
            rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues and a 16-deep FIFO model drive the DUT, a transaction-level arbiter model checks it.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();
  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0] pq[NREQ][$];
  bit         en[NREQ];
  bit         req_v[NREQ];
  logic [7:0] fq[$];

  int owner  = -1;
  int nwr    = 0;
  int nstart = 0;

  logic [3:0] gnt_tr[$];
  logic       wr_tr[$];

  logic [3:0] e_gnt, e_ack;
  logic       e_wr, e_busy;
  logic [7:0] e_din;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [8:0] w;
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = en[i] && (pq[i].size() > 0);
      w = (pq[i].size() > 0) ? pq[i][0] : 9'h000;
      bus.req[i]             = req_v[i];
      bus.last[i]            = w[8];
      bus.data[i*DW +: DW]   = w[7:0];
    end
    bus.fifo_full = (fq.size() >= DEPTH);
  endtask

  task automatic model_outputs();
    logic [8:0] w;
    e_busy = (owner >= 0);
    e_gnt  = '0;
    e_din  = '0;
    e_wr   = 1'b0;
    if (owner >= 0) begin
      e_gnt[owner] = 1'b1;
      w     = (pq[owner].size() > 0) ? pq[owner][0] : 9'h000;
      e_din = w[7:0];
      e_wr  = req_v[owner] && (fq.size() < DEPTH);
    end
    e_ack = e_wr ? e_gnt : 4'b0000;
  endtask

  task automatic compare();
    check("gnt",      bus.gnt,      e_gnt);
    check("ack",      bus.ack,      e_ack);
    check("fifo_wr",  bus.fifo_wr,  e_wr);
    check("busy",     bus.busy,     e_busy);
    if (e_busy) check("fifo_din", bus.fifo_din, e_din);
    else        check("fifo_din_idle", bus.fifo_din, 0);
  endtask

  task automatic step(input bit pop);
    int  nown, nnwr, nns;
    bit  rel;
    logic [8:0] w;
    nown = owner; nnwr = nwr; nns = nstart; rel = 1'b0;
    if (owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (nown < 0 && req_v[(nstart + k) % NREQ]) begin
          nown = (nstart + k) % NREQ;
          nnwr = 0;
        end
      end
    end else if (!req_v[owner]) begin
      rel = 1'b1;
    end else if (e_wr) begin
      w    = pq[owner][0];
      nnwr = nwr + 1;
      if (w[8] || nnwr == MB) rel = 1'b1;
    end
    if (rel) begin
      nns  = (owner + 1) % NREQ;
      nown = -1;
    end
    @(posedge clk);
    if (pop && fq.size() > 0) void'(fq.pop_front());
    if (e_wr) begin
      fq.push_back(e_din);
      void'(pq[owner].pop_front());
    end
    owner = nown; nwr = nnwr; nstart = nns;
  endtask

  task automatic cycle(input bit pop);
    @(negedge clk);
    drive();
    #1;
    model_outputs();
    compare();
    gnt_tr.push_back(bus.gnt);
    wr_tr.push_back(bus.fifo_wr);
    step(pop);
  endtask

  task automatic check_traces(input string nm, input logic [3:0] eg[$], input logic ew[$]);
    check($sformatf("%s_len", nm), gnt_tr.size(), eg.size());
    for (int i = 0; i < eg.size(); i++) begin
      check($sformatf("%s_gnt[%0d]", nm, i), (i < gnt_tr.size()) ? gnt_tr[i] : 4'hx, eg[i]);
      check($sformatf("%s_wr[%0d]",  nm, i), (i < wr_tr.size())  ? wr_tr[i]  : 1'bx, ew[i]);
    end
  endtask

  task automatic check_fifo(input string nm, input logic [7:0] ef[$]);
    check($sformatf("%s_size", nm), fq.size(), ef.size());
    for (int i = 0; i < ef.size(); i++)
      check($sformatf("%s[%0d]", nm, i), (i < fq.size()) ? fq[i] : 8'hxx, ef[i]);
  endtask

  task automatic begin_test();
    gnt_tr.delete();
    wr_tr.delete();
    fq.delete();
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1'b0;
      pq[i].delete();
    end
  endtask

  initial begin
    logic [3:0] eg[$];
    logic       ew[$];
    logic [7:0] ef[$];
    bit         pops[$];

    // Reset with every producer requesting: nothing may be granted.
    bus.req       = '1;
    bus.last      = '0;
    bus.data      = '1;
    bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",  bus.gnt,      0);
    check("rst_busy", bus.busy,     0);
    check("rst_wr",   bus.fifo_wr,  0);
    check("rst_ack",  bus.ack,      0);
    check("rst_din",  bus.fifo_din, 0);
    bus.req = '0;
    rst     = 1'b0;

    // Round-robin fairness: all four producers with 2-word packets.
    begin_test();
    for (int i = 0; i < NREQ; i++) begin
      pq[i].push_back({1'b0, 8'(16*i)});
      pq[i].push_back({1'b1, 8'(16*i + 1)});
      en[i] = 1'b1;
    end
    repeat (13) cycle(1'b0);
    eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
    ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    check_traces("rr", eg, ew);
    ef = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
    check_fifo("rr_fifo", ef);
    check("rr_ptr_model", nstart, 0);

    // Single producer, 6-word packet split by MAX_BURST.
    begin_test();
    for (int k = 0; k < 6; k++) pq[1].push_back({(k == 5), 8'(8'hA0 + k)});
    en[1] = 1'b1;
    repeat (9) cycle(1'b0);
    eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    check_traces("single", eg, ew);
    ef = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    check_fifo("single_fifo", ef);

    // Withdrawal: producer 3 drops req after one word.
    begin_test();
    pq[3].push_back({1'b0, 8'h77});
    pq[3].push_back({1'b1, 8'h78});
    en[3] = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    en[3] = 1'b0;
    cycle(1'b0);
    pq[0].push_back({1'b1, 8'h55});
    pq[1].push_back({1'b1, 8'h66});
    en[0] = 1'b1;
    en[1] = 1'b1;
    repeat (5) cycle(1'b0);
    eg = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    check_traces("withdraw", eg, ew);
    ef = '{8'h77, 8'h55, 8'h66};
    check_fifo("withdraw_fifo", ef);

    // Full stall: FIFO at 15, producer 2 offers three words, pops release the stall.
    begin_test();
    for (int k = 0; k < 15; k++) fq.push_back(8'(8'hE0 + k));
    for (int k = 0; k < 3; k++) pq[2].push_back({(k == 2), 8'(8'hC0 + k)});
    en[2] = 1'b1;
    pops = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 8; c++) cycle(pops[c]);
    eg = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    check_traces("full", eg, ew);
    check("full_size", fq.size(), 16);
    check("full_c0", fq[13], 8'hC0);
    check("full_c1", fq[14], 8'hC1);
    check("full_c2", fq[15], 8'hC2);

    // last on the MAX_BURST-th word, then a 5-word packet that needs a fresh count.
    begin_test();
    for (int k = 0; k < 4; k++) pq[0].push_back({(k == 3), 8'(8'hD0 + k)});
    for (int k = 0; k < 5; k++) pq[0].push_back({(k == 4), 8'(8'hD4 + k)});
    en[0] = 1'b1;
    repeat (13) cycle(1'b0);
    eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    check_traces("bothend", eg, ew);
    ef = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8};
    check_fifo("bothend_fifo", ef);

    // Asynchronous reset in the middle of producer 0's burst.
    begin_test();
    for (int k = 0; k < 4; k++) pq[0].push_back({(k == 3), 8'(8'hB0 + k)});
    en[0] = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    @(negedge clk);
    drive();
    #2 rst = 1'b1;
    #1;
    check("arst_gnt",  bus.gnt,     0);
    check("arst_busy", bus.busy,    0);
    check("arst_wr",   bus.fifo_wr, 0);
    check("arst_ack",  bus.ack,     0);
    fq.delete();
    owner = -1; nwr = 0; nstart = 0;
    check("arst_fifo_empty", fq.size(), 0);
    bus.req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    gnt_tr.delete();
    wr_tr.delete();
    pq[1].push_back({1'b1, 8'hBB});
    en[1] = 1'b1;
    repeat (7) cycle(1'b0);
    eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    check_traces("arst", eg, ew);
    ef = '{8'hB1, 8'hB2, 8'hB3, 8'hBB};
    check_fifo("arst_fifo", ef);

    // Randomised traffic: packets, request gaps, occasional withdrawal, random FIFO drain.
    begin_test();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pq[i].size() == 0 && $urandom_range(3) == 0) begin
          int len;
          len = $urandom_range(6, 1);
          for (int k = 0; k < len; k++) pq[i].push_back({(k == len - 1), 8'($urandom)});
        end
        if (!en[i]) begin
          if ($urandom_range(2) == 0) en[i] = 1'b1;
        end else if ($urandom_range(49) == 0) begin
          en[i] = 1'b0;
        end
      end
      cycle($urandom_range(99) < 45);
      if (gnt_tr.size() > 64) begin
        gnt_tr.delete();
        wr_tr.delete();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
